// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg
// Shared definitions for the UART baud-rate generator:
//   - DEF_CNTR_W, DEF_FRAC_W, DEF_OVS : default parameter values
//   - PHASE_W(ovs)                    : width of the oversample phase counter
//   - params_legal(...)               : parameter legality test used at elaboration
package uart_baud_pkg;

    localparam int DEF_CNTR_W = 16;
    localparam int DEF_FRAC_W = 4;
    localparam int DEF_OVS    = 16;

    function automatic int PHASE_W(input int ovs);
        return $clog2(ovs);
    endfunction

    // OVS must be a power of two so the phase counter wraps by simple overflow.
    function automatic bit params_legal(input int cntr_w, input int frac_w, input int ovs);
        return (cntr_w >= 2) && (frac_w >= 1) && (ovs >= 4) && ((ovs & (ovs - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_frac_accum.sv
// uart_frac_accum
// Fractional accumulator for the baud generator. Each tick adds frac_r into a
// FRAC_W-bit accumulator; the carry out becomes the stretch flag, which asks the
// parent to insert one extra clock into the next period.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   tick       : baud tick, advances the accumulator
//   slip       : the parent is spending its extra cycle; clears stretch
//   clear      : restart (cfg_load or resync), zeroes accumulator and stretch
//   frac_r     : captured fractional numerator
//   stretch    : one extra cycle owed before the next tick
module uart_frac_accum
    import uart_baud_pkg::*;
#(
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              slip,
    input  logic              clear,
    input  logic [FRAC_W-1:0] frac_r,
    output logic              stretch
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              stretch_q, stretch_d;
    logic [FRAC_W:0]   sum;

    // Accumulator next state: the carry bit of acc + frac_r is the stretch request.
    always_comb begin
        acc_d     = acc_q;
        stretch_d = stretch_q;
        sum       = {1'b0, acc_q} + {1'b0, frac_r};
        if (clear) begin
            acc_d     = '0;
            stretch_d = 1'b0;
        end else if (tick) begin
            acc_d     = sum[FRAC_W-1:0];
            stretch_d = sum[FRAC_W];
        end else if (slip) begin
            stretch_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            stretch_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            stretch_q <= stretch_d;
        end
    end

    assign stretch = stretch_q;

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Fractional baud-rate generator. Divides clk into an OVS-times oversampling
// tick (baud_clock), a once-per-bit xmit_pulse and a mid-bit sample_pulse.
// Optional macro UART_BAUD_FRAC_EN builds the fractional accumulator; without
// it baud_frac is ignored and the period is exactly div_r+1 clocks.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   enable       : run control, counters hold while low
//   baud_val     : integer divisor minus one (captured on reset / cfg_load)
//   baud_frac    : fractional numerator (captured on reset / cfg_load)
//   cfg_load     : capture divisor and restart the period
//   resync       : zero the phase and restart the period
//   baud_clock   : oversampling tick
//   xmit_pulse   : bit-boundary tick
//   sample_pulse : mid-bit tick
//   phase        : current oversample phase
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int CNTR_W = DEF_CNTR_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OVS    = DEF_OVS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CNTR_W-1:0]       baud_val,
    input  logic [FRAC_W-1:0]       baud_frac,
    input  logic                    cfg_load,
    input  logic                    resync,
    output logic                    baud_clock,
    output logic                    xmit_pulse,
    output logic                    sample_pulse,
    output logic [PHASE_W(OVS)-1:0] phase
);

    localparam int            PW         = PHASE_W(OVS);
    localparam logic [PW-1:0] PHASE_LAST = PW'(OVS - 1);
    localparam logic [PW-1:0] PHASE_MID  = PW'(OVS / 2 - 1);

    generate
        if (!params_legal(CNTR_W, FRAC_W, OVS)) begin : g_bad_params
            $error("uart_baud_gen: illegal CNTR_W/FRAC_W/OVS combination");
        end
    endgenerate

    logic [CNTR_W-1:0] div_q, div_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [CNTR_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              baud_clock_q, baud_clock_d;
    logic              xmit_pulse_q, xmit_pulse_d;
    logic              sample_pulse_q, sample_pulse_d;
    logic              stretch;
    logic              tick;

    // A restart request (cfg_load or resync) takes the cycle, so no tick may fire in it.
    assign tick = enable && !cfg_load && !resync && (cnt_q == '0) && !stretch;

`ifdef UART_BAUD_FRAC_EN
    logic slip;

    // The extra cycle: counter sits at zero while the owed stretch is consumed.
    assign slip = enable && !cfg_load && !resync && (cnt_q == '0) && stretch;

    uart_frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_frac_accum (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .slip    (slip),
        .clear   (cfg_load | resync),
        .frac_r  (frac_q),
        .stretch (stretch)
    );
`else
    logic unused_frac;

    assign stretch     = 1'b0;
    assign unused_frac = ^frac_q;
`endif

    // Next-state for shadow registers, period counter and phase.
    // cfg_load reloads from the live inputs, resync restarts from the shadow value.
    always_comb begin
        div_d   = div_q;
        frac_d  = frac_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (cfg_load) begin
            div_d  = baud_val;
            frac_d = baud_frac;
            cnt_d  = baud_val;
            if (resync) begin
                phase_d = '0;
            end
        end else if (resync) begin
            cnt_d   = div_q;
            phase_d = '0;
        end else if (enable) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNTR_W'(1);
            end else if (!stretch) begin
                cnt_d   = div_q;
                phase_d = phase_q + PW'(1);
            end
        end
        baud_clock_d   = tick;
        xmit_pulse_d   = tick && (phase_q == PHASE_LAST);
        sample_pulse_d = tick && (phase_q == PHASE_MID);
    end

    // Reset captures the divisor inputs so the generator runs straight away.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q          <= baud_val;
            frac_q         <= baud_frac;
            cnt_q          <= '0;
            phase_q        <= '0;
            baud_clock_q   <= 1'b0;
            xmit_pulse_q   <= 1'b0;
            sample_pulse_q <= 1'b0;
        end else begin
            div_q          <= div_d;
            frac_q         <= frac_d;
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
            baud_clock_q   <= baud_clock_d;
            xmit_pulse_q   <= xmit_pulse_d;
            sample_pulse_q <= sample_pulse_d;
        end
    end

    assign baud_clock   = baud_clock_q;
    assign xmit_pulse   = xmit_pulse_q;
    assign sample_pulse = sample_pulse_q;
    assign phase        = phase_q;

endmodule
